// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions for the sprite-DMA path: FSM state encoding and
// the fixed register addresses used as parameter defaults.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_TRIG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_PORT_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA engine: a trigger write stalls the CPU and copies XFER_LEN bytes
// from the selected page to the OAM data port. Define OAM_DMA_ALIGN_EN for odd-cycle alignment.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int XFER_LEN = 256,
  parameter logic [ADDR_W-1:0] TRIG_ADDR     = ADDR_W'(OAM_DMA_TRIG_ADDR),
  parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = ADDR_W'(OAM_DATA_PORT_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              dma_rd,
  output logic              dma_wr,
  output logic [DATA_W-1:0] dma_wdata,
  output logic              stall,
  output logic              busy,
  output logic              done
);

  localparam int PAGE_W = ADDR_W - 8;
  localparam int IDX_W  = $clog2(XFER_LEN) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

  dma_state_t        state;
  dma_state_t        next_state;
  logic [PAGE_W-1:0] page;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] latch;
  logic              trig;

  assign trig = cpu_wr && (cpu_addr == TRIG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
  logic odd;

  // Bus-cycle parity, tracked independently of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) odd <= 1'b0;
    else        odd <= ~odd;
  end
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (trig) next_state = HALT;
`ifdef OAM_DMA_ALIGN_EN
      HALT:  next_state = odd ? ALIGN : READ;
`else
      HALT:  next_state = READ;
`endif
      ALIGN: next_state = READ;
      READ:  next_state = WRITE;
      WRITE: next_state = (idx == LAST_IDX) ? DONE : READ;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Triggers outside IDLE are dropped, so page/idx only load from IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page  <= '0;
      idx   <= '0;
      latch <= '0;
    end else begin
      if (state == IDLE && trig) begin
        page <= PAGE_W'(cpu_wdata);
        idx  <= '0;
      end
      if (state == READ) latch <= dma_rdata;
      if (state == WRITE && idx != LAST_IDX) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    dma_rd    = (state == READ);
    dma_wr    = (state == WRITE);
    dma_addr  = '0;
    dma_wdata = '0;
    if (state == READ)  dma_addr = {page, 8'(idx)};
    if (state == WRITE) begin
      dma_addr  = OAM_DATA_ADDR;
      dma_wdata = latch;
    end
    stall = (state == HALT) || (state == ALIGN) || (state == READ) || (state == WRITE);
    busy  = (state != IDLE);
    done  = (state == DONE);
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: a 256-byte instance and a 4-byte instance
// share the clock, reset and CPU bus; each has its own trigger strobe.
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAMD = 16'h2004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr_a, cpu_wr_b;
  logic        tb_odd;

  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_rdata, b_rdata, a_wdata, b_wdata;
  logic        a_rd, a_wr, a_stall, a_busy, a_done;
  logic        b_rd, b_wr, b_stall, b_busy, b_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Source memory: page 7 holds A0, A1, ...; other pages a simple address hash
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a[15:8] == 8'h07) return 8'hA0 + a[7:0];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign a_rdata = mem_byte(a_addr);
  assign b_rdata = mem_byte(b_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_odd <= 1'b0;
    else        tb_odd <= ~tb_odd;
  end

  oam_dma_ctrl #(.XFER_LEN(256)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr_a),
    .cpu_wdata(cpu_wdata), .dma_rdata(a_rdata), .dma_addr(a_addr),
    .dma_rd(a_rd), .dma_wr(a_wr), .dma_wdata(a_wdata),
    .stall(a_stall), .busy(a_busy), .done(a_done)
  );

  oam_dma_ctrl #(.XFER_LEN(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr_b),
    .cpu_wdata(cpu_wdata), .dma_rdata(b_rdata), .dma_addr(b_addr),
    .dma_rd(b_rd), .dma_wr(b_wr), .dma_wdata(b_wdata),
    .stall(b_stall), .busy(b_busy), .done(b_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Packed view {stall,busy,done,rd,wr,addr,wdata}; wdata only meaningful on writes
  function automatic logic [31:0] obsVec(input bit s, input bit keep_wdata);
    if (s) return {3'b0, b_stall, b_busy, b_done, b_rd, b_wr, b_addr, keep_wdata ? b_wdata : 8'h00};
    return {3'b0, a_stall, a_busy, a_done, a_rd, a_wr, a_addr, keep_wdata ? a_wdata : 8'h00};
  endfunction

  task automatic setWr(input bit s, input logic v);
    if (s) cpu_wr_b = v;
    else   cpu_wr_a = v;
  endtask

  task automatic applyStimulus(input bit s, input logic [7:0] pg, input int len, input bit want_odd,
                               input int inject_mid, input bit inject_done, input int abort_idx);
    int a, last, stall_cnt, done_cnt, k, i;
    logic e_stall, e_busy, e_done, e_rd, e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic [31:0] o;
    bit inj;
    string nm;
    nm = s ? "B" : "A";
    // Parity flips at the trigger edge, so drive when it is the opposite of the wanted HALT value
    @(negedge clk);
    if (tb_odd == want_odd) @(negedge clk);
    cpu_addr  = TRIG;
    cpu_wdata = pg;
    setWr(s, 1'b1);
    a = (ALIGN_EN && want_odd) ? 1 : 0;
    last = 1 + a + 2 * len;
    stall_cnt = 0;
    done_cnt  = 0;
    for (int cyc = 0; cyc <= last + 1; cyc++) begin
      @(negedge clk);
      e_stall = 0; e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0;
      e_addr = 16'h0; e_wdata = 8'h0; i = -1;
      if (cyc < 1 + a) begin
        e_stall = 1; e_busy = 1;
      end else if (cyc < last) begin
        k = cyc - 1 - a;
        i = k / 2;
        e_stall = 1; e_busy = 1;
        if (k % 2 == 0) begin
          e_rd = 1; e_addr = {pg, 8'(i)};
        end else begin
          e_wr = 1; e_addr = OAMD; e_wdata = mem_byte({pg, 8'(i)});
        end
      end else if (cyc == last) begin
        e_busy = 1; e_done = 1;
      end
      o = obsVec(s, e_wr);
      checkOutput($sformatf("%s_pg%02h_c%0d", nm, pg, cyc), o,
                  {3'b0, e_stall, e_busy, e_done, e_rd, e_wr, e_addr, e_wdata});
      if (o[28]) stall_cnt++;
      if (o[26]) done_cnt++;
      if (e_rd && i == abort_idx) begin
        setWr(s, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput($sformatf("%s_async_rst", nm), obsVec(s, 1'b0), 32'h0);
        @(negedge clk);
        checkOutput($sformatf("%s_rst_hold", nm), obsVec(s, 1'b0), 32'h0);
        rst_n = 1'b1;
        return;
      end
      inj = (e_rd && i == inject_mid) || (cyc == last && inject_done);
      if (inj) cpu_wdata = pg ^ 8'h55;
      setWr(s, inj);
    end
    checkOutput($sformatf("%s_pg%02h_stall_cycles", nm, pg), 32'(stall_cnt), 32'(1 + a + 2 * len));
    checkOutput($sformatf("%s_pg%02h_done_pulses", nm, pg), 32'(done_cnt), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_addr = 16'h0; cpu_wdata = 8'h0; cpu_wr_a = 1'b0; cpu_wr_b = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("A_reset", obsVec(1'b0, 1'b1), 32'h0);
    checkOutput("B_reset", obsVec(1'b1, 1'b1), 32'h0);
    rst_n = 1'b1;

    applyStimulus(1'b0, 8'h02, 256, 1'b0, -1, 1'b0, -1);
    applyStimulus(1'b0, 8'h02, 256, 1'b1, -1, 1'b0, -1);
    applyStimulus(1'b1, 8'h07, 4,   1'b0, -1, 1'b0, -1);
    applyStimulus(1'b1, 8'h07, 4,   1'b1, -1, 1'b0, -1);
    applyStimulus(1'b1, 8'h07, 4,   1'b0,  1, 1'b1, -1);
    applyStimulus(1'b0, 8'h05, 256, 1'b1, 128, 1'b1, -1);
    applyStimulus(1'b0, 8'h03, 256, 1'b0, -1, 1'b0, 100);
    applyStimulus(1'b0, 8'h03, 256, 1'b1, -1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
